lab2_proc_inst_buffer: RTL and testbench

In-order fetch buffer between the instruction memory port and the decode stage. It allocates an entry per issued fetch, fills entries as in-order memory responses return, and presents the oldest completed {pc, inst} to decode with a val/rdy handshake. Decode then drives immediate generation and the control unit. It also absorbs redirect squashes by discarding buffered entries and dropping responses still in flight.

---
 rtl/lab2_proc_pkg.sv | 12 +
 rtl/lab2_proc_inst_buffer_ptr.sv | 39 +++
 rtl/lab2_proc_inst_buffer.sv | 162 ++++++++++++++++
 tb/tb_lab2_proc_inst_buffer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lab2_proc_pkg.sv
// rtl/lab2_proc_pkg.sv - shared types for the lab2 processor fetch path
package lab2_proc_pkg;

    // One fetch-buffer slot: request PC, returned word, and whether the
    // memory response for this slot has landed yet.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        arrived;
    } inst_buf_entry_t;

endpackage

// File: rtl/lab2_proc_inst_buffer_ptr.sv
// rtl/lab2_proc_inst_buffer_ptr.sv - wrap-around pointer with clear and increment
//
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   clear_i     return the pointer to slot 0
//   inc_i       advance the pointer by one (applied after clear_i)
//   ptr_o       current pointer value
module lab2_proc_inst_buffer_ptr #(
    parameter int p_num_entries = 2,
    localparam int PW = $clog2(p_num_entries)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // clear and inc together land on slot 1, which is what a squash plus a
    // same-cycle redirect allocation needs. Depth is a power of two, so the
    // natural binary wrap is the modulo.
    always_comb begin
        ptr_d = (clear_i ? '0 : ptr_q) + PW'(inc_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/lab2_proc_inst_buffer.sv
// rtl/lab2_proc_inst_buffer.sv - in-order fetch buffer between imem and decode
//
// Ports:
//   clk, reset                 clock and asynchronous active-high reset
//   memreq_fire, memreq_pc     fetch issued a request for memreq_pc this cycle
//   issue_ok                   fetch may issue a request this cycle
//   memresp_val, memresp_data  in-order imem response
//   memresp_rdy                constant 1, responses are never stalled
//   squash                     redirect: discard buffer, drop in-flight responses
//   inst_val_D, inst_D, pc_D   oldest completed entry presented to decode
//   inst_rdy_D                 decode accepts the head entry
module lab2_proc_inst_buffer
    import lab2_proc_pkg::*;
#(
    parameter int p_num_entries = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_fire,
    input  logic [31:0] memreq_pc,
    output logic        issue_ok,
    input  logic        memresp_val,
    input  logic [31:0] memresp_data,
    output logic        memresp_rdy,
    input  logic        squash,
    output logic        inst_val_D,
    output logic [31:0] inst_D,
    output logic [31:0] pc_D,
    input  logic        inst_rdy_D
);

    localparam int PW = $clog2(p_num_entries);
    localparam int CW = $clog2(p_num_entries + 1);
    localparam logic [CW-1:0] NUM = CW'(p_num_entries);

    inst_buf_entry_t entries_q [p_num_entries];
    inst_buf_entry_t entries_d [p_num_entries];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] fill;
    logic [PW-1:0] alloc_idx;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] drop_q;
    logic [CW-1:0] drop_d;
    logic [CW-1:0] arrived_cnt;
    logic [CW-1:0] pending;
    logic [CW:0]   drop_sum;

    logic alloc;
    logic deq;
    logic resp_drop;
    logic resp_fill;

    assign issue_ok    = (count_q < NUM);
    assign memresp_rdy = 1'b1;

    // Arrived bits are cleared on dequeue and squash, so only live entries
    // can hold one; the head being arrived means a completed instruction.
    assign inst_val_D = entries_q[head].arrived;
    assign inst_D     = entries_q[head].inst;
    assign pc_D       = entries_q[head].pc;

    always_comb begin
        arrived_cnt = '0;
        for (int i = 0; i < p_num_entries; i++) begin
            arrived_cnt = arrived_cnt + CW'(entries_q[i].arrived);
        end
    end

    assign pending = count_q - arrived_cnt;

    // A redirect target is fired into the buffer that the squash empties,
    // so it is accepted even when the old contents filled every slot.
    assign alloc     = memreq_fire && (issue_ok || squash);
    assign deq       = inst_val_D && inst_rdy_D && !squash;
    assign resp_drop = memresp_val && (drop_q != '0);
    assign resp_fill = memresp_val && (drop_q == '0) && (pending != '0);
    assign alloc_idx = squash ? '0 : tail;

    always_comb begin
        // Everything still owed by memory becomes a drop, minus the
        // response consumed this cycle (by the drop counter or a fill).
        drop_sum = {1'b0, drop_q} + {1'b0, pending} - (CW+1)'(resp_drop || resp_fill);
        if (squash) begin
            drop_d = (drop_sum > {1'b0, NUM}) ? NUM : drop_sum[CW-1:0];
        end else begin
            drop_d = drop_q - CW'(resp_drop);
        end
    end

    always_comb begin
        if (squash) begin
            count_d = CW'(alloc);
        end else begin
            count_d = count_q + CW'(alloc) - CW'(deq);
        end
    end

    always_comb begin
        entries_d = entries_q;
        if (squash) begin
            for (int i = 0; i < p_num_entries; i++) begin
                entries_d[i].arrived = 1'b0;
            end
        end else begin
            if (resp_fill) begin
                entries_d[fill].inst    = memresp_data;
                entries_d[fill].arrived = 1'b1;
            end
            if (deq) begin
                entries_d[head].arrived = 1'b0;
            end
        end
        if (alloc) begin
            entries_d[alloc_idx].pc      = memreq_pc;
            entries_d[alloc_idx].inst    = '0;
            entries_d[alloc_idx].arrived = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < p_num_entries; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
            drop_q  <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
            drop_q    <= drop_d;
        end
    end

    lab2_proc_inst_buffer_ptr #(.p_num_entries(p_num_entries)) u_head_ptr (
        .clk     (clk),
        .reset   (reset),
        .clear_i (squash),
        .inc_i   (deq),
        .ptr_o   (head)
    );

    lab2_proc_inst_buffer_ptr #(.p_num_entries(p_num_entries)) u_tail_ptr (
        .clk     (clk),
        .reset   (reset),
        .clear_i (squash),
        .inc_i   (alloc),
        .ptr_o   (tail)
    );

    lab2_proc_inst_buffer_ptr #(.p_num_entries(p_num_entries)) u_fill_ptr (
        .clk     (clk),
        .reset   (reset),
        .clear_i (squash),
        .inc_i   (resp_fill && !squash),
        .ptr_o   (fill)
    );

endmodule

// File: tb/tb_lab2_proc_inst_buffer.sv
// tb/tb_lab2_proc_inst_buffer.sv - scoreboard bench for the fetch buffer
module tb_lab2_proc_inst_buffer;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreq_fire;
    logic [31:0] memreq_pc;
    logic        issue_ok;
    logic        memresp_val;
    logic [31:0] memresp_data;
    logic        memresp_rdy;
    logic        squash;
    logic        inst_val_D;
    logic [31:0] inst_D;
    logic [31:0] pc_D;
    logic        inst_rdy_D;

    always #5 clk = ~clk;

    lab2_proc_inst_buffer #(.p_num_entries(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .memreq_fire  (memreq_fire),
        .memreq_pc    (memreq_pc),
        .issue_ok     (issue_ok),
        .memresp_val  (memresp_val),
        .memresp_data (memresp_data),
        .memresp_rdy  (memresp_rdy),
        .squash       (squash),
        .inst_val_D   (inst_val_D),
        .inst_D       (inst_D),
        .pc_D         (pc_D),
        .inst_rdy_D   (inst_rdy_D)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem_q  [$];
    logic [31:0] pend_q [$];
    logic [63:0] rdy_q  [$];
    int          drop_m = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'h00A00093 ^ ((pc - 32'h200) << 12);
    endfunction

    task automatic step(input logic fire, input logic [31:0] pc, input logic rv,
                        input logic sq, input logic rdy, output logic acc);
        logic [31:0] data;
        logic [63:0] head_e;
        logic        m_ok;
        logic        took;
        int          pb;
        data = 32'hDEADBEEF;
        if (rv && mem_q.size() > 0) data = inst_of(mem_q.pop_front());
        memreq_fire  = fire;
        memreq_pc    = pc;
        memresp_val  = rv;
        memresp_data = data;
        squash       = sq;
        inst_rdy_D   = rdy;
        m_ok = (pend_q.size() + rdy_q.size()) < N;
        acc  = fire && (m_ok || sq);
        #1;
        check("inst_val_D", 64'(inst_val_D), 64'(rdy_q.size() > 0));
        check("issue_ok", 64'(issue_ok), 64'(m_ok));
        check("memresp_rdy", 64'(memresp_rdy), 64'(1));
        if (rdy_q.size() > 0) begin
            head_e = rdy_q[0];
            check("pc_D", 64'(pc_D), 64'(head_e[63:32]));
            check("inst_D", 64'(inst_D), 64'(head_e[31:0]));
            if (rdy && !sq) void'(rdy_q.pop_front());
        end
        if (acc) mem_q.push_back(pc);
        @(posedge clk);
        pb   = pend_q.size();
        took = 1'b0;
        if (rv) begin
            if (drop_m > 0) begin
                drop_m--;
            end else if (pb > 0) begin
                rdy_q.push_back({pend_q.pop_front(), data});
                took = 1'b1;
            end
        end
        if (sq) begin
            drop_m = drop_m + pb - int'(took);
            if (drop_m > N) drop_m = N;
            pend_q.delete();
            rdy_q.delete();
        end
        if (acc) pend_q.push_back(pc);
        @(negedge clk);
    endtask

    logic        a;
    logic        rv_n;
    logic [31:0] nxt;

    initial begin
        reset = 1'b1;
        memreq_fire = 1'b0; memreq_pc = '0; memresp_val = 1'b0;
        memresp_data = '0; squash = 1'b0; inst_rdy_D = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_inst_val_D", 64'(inst_val_D), 64'(0));
        check("rst_issue_ok", 64'(issue_ok), 64'(1));
        check("rst_pc_D", 64'(pc_D), 64'(0));
        check("rst_inst_D", 64'(inst_D), 64'(0));
        reset = 1'b0;

        // single fetch
        step(1, 32'h200, 0, 0, 1, a);
        step(0, 32'h0,   1, 0, 1, a);
        check("single_pc_D", 64'(pc_D), 64'(32'h200));
        check("single_inst_D", 64'(inst_D), 64'(32'h00A00093));
        step(0, 32'h0,   0, 0, 1, a);
        step(0, 32'h0,   0, 0, 1, a);

        // streaming with 1-cycle memory, fetch retries when not allowed
        nxt = 32'h200; rv_n = 1'b0;
        for (int i = 0; i < 24; i++) begin
            step(nxt < 32'h220, nxt, rv_n, 0, 1, a);
            rv_n = a;
            if (a) nxt = nxt + 32'h4;
        end
        step(0, 32'h0, rv_n, 0, 1, a);
        repeat (3) step(0, 32'h0, 0, 0, 1, a);

        // decode stall: third fire ignored, head held stable
        step(1, 32'h200, 0, 0, 0, a);
        step(1, 32'h204, 1, 0, 0, a);
        step(1, 32'h208, 1, 0, 0, a);
        check("stall_issue_ok", 64'(issue_ok), 64'(0));
        step(1, 32'h208, 0, 0, 0, a);
        check("stall_pc_D", 64'(pc_D), 64'(32'h200));
        repeat (3) step(0, 32'h0, 0, 0, 1, a);

        // squash with two in flight plus redirect fire
        step(1, 32'h200, 0, 0, 1, a);
        step(1, 32'h204, 0, 0, 1, a);
        step(1, 32'h300, 0, 1, 1, a);
        step(0, 32'h0,   1, 0, 1, a);
        step(0, 32'h0,   1, 0, 1, a);
        check("sq_drop_val", 64'(inst_val_D), 64'(0));
        step(0, 32'h0,   1, 0, 1, a);
        check("sq_target_pc", 64'(pc_D), 64'(32'h300));
        repeat (2) step(0, 32'h0, 0, 0, 1, a);

        // squash coinciding with the only pending response
        step(1, 32'h400, 0, 0, 1, a);
        step(0, 32'h0,   1, 1, 1, a);
        step(0, 32'h0,   0, 0, 1, a);
        step(1, 32'h404, 0, 0, 1, a);
        step(0, 32'h0,   1, 0, 1, a);
        check("post_sq_pc", 64'(pc_D), 64'(32'h404));
        repeat (2) step(0, 32'h0, 0, 0, 1, a);

        // asynchronous reset with two completed entries
        step(1, 32'h500, 0, 0, 0, a);
        step(1, 32'h504, 1, 0, 0, a);
        step(0, 32'h0,   1, 0, 0, a);
        step(0, 32'h0,   0, 0, 0, a);
        #2 reset = 1'b1;
        #1;
        check("arst_inst_val_D", 64'(inst_val_D), 64'(0));
        check("arst_issue_ok", 64'(issue_ok), 64'(1));
        check("arst_pc_D", 64'(pc_D), 64'(0));
        check("arst_inst_D", 64'(inst_D), 64'(0));
        mem_q.delete(); pend_q.delete(); rdy_q.delete(); drop_m = 0;
        @(negedge clk);
        reset = 1'b0;
        step(0, 32'h0, 1, 0, 1, a);
        step(0, 32'h0, 0, 0, 1, a);
        step(1, 32'h600, 0, 0, 1, a);
        step(0, 32'h0,   1, 0, 1, a);
        step(0, 32'h0,   0, 0, 1, a);
        step(0, 32'h0,   0, 0, 1, a);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
